// File: rtl/bus_pkg.sv
// Shared state encoding and index-width helper for the bus driver arbiter and its
// round-robin picker.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    // Never narrower than one bit, so single-value counters still have a legal width.
    function automatic int unsigned clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// returns the first requesting index.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned SOURCES = 4
) (
    input  logic [SOURCES-1:0]        req,
    input  logic [clog2(SOURCES)-1:0] ptr,
    output logic [clog2(SOURCES)-1:0] pick,
    output logic                      any_req
);

    localparam int unsigned IW  = clog2(SOURCES);
    localparam int unsigned IW1 = IW + 1;

    logic [IW:0] idx;
    logic        found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= SOURCES; i++) begin
            // One extra bit holds ptr+i, so a single subtraction performs the wrap.
            idx = {1'b0, ptr} + IW1'(i);
            if (idx >= IW1'(SOURCES)) begin
                idx = idx - IW1'(SOURCES);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_driver_arbiter.sv
// Round-robin shared-bus driver with a high-impedance turnaround gap and a hold cap.
// Define BUS_PARK_EN to park bus_out on the last owner's data while idle.
module bus_driver_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SOURCES     = 4,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SOURCES-1:0]          req,
    input  logic [SOURCES*WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]            bus_out,
    output logic [SOURCES-1:0]          grant,
    output logic [clog2(SOURCES)-1:0]   owner,
    output logic                        bus_busy
);

    localparam int unsigned   IW        = clog2(SOURCES);
    localparam int unsigned   HW        = clog2(MAX_HOLD + 1);
    localparam int unsigned   TW        = clog2(TURN_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [IW-1:0] OWNER_RST = IW'(SOURCES - 1);

    state_e          state;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   turn_cnt;
    logic [IW-1:0]   pick;
    logic            any_req;
    logic            forced_release;
    logic            drive_en;
    logic [WIDTH-1:0] slices [SOURCES];

    for (genvar i = 0; i < SOURCES; i++) begin : g_slice
        assign slices[i] = data_in[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .SOURCES (SOURCES)
    ) u_rr (
        .req     (req),
        .ptr     (owner),
        .pick    (pick),
        .any_req (any_req)
    );

    // In DRIVE the grant is the owner's one-hot, so masking it leaves only competitors.
    assign forced_release = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|(req & ~grant));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= OWNER_RST;
            hold_cnt <= '0;
            turn_cnt <= '0;
            bus_busy <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= ST_DRIVE;
                        grant    <= SOURCES'(1) << pick;
                        owner    <= pick;
                        hold_cnt <= '0;
                        bus_busy <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!req[owner] || forced_release) begin
                        state    <= ST_TURN;
                        grant    <= '0;
                        turn_cnt <= '0;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        if (any_req) begin
                            state    <= ST_DRIVE;
                            grant    <= SOURCES'(1) << pick;
                            owner    <= pick;
                            hold_cnt <= '0;
                        end else begin
                            state    <= ST_IDLE;
                            bus_busy <= 1'b0;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    grant    <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_PARK_EN
    assign drive_en = (|grant) || (state == ST_IDLE);
`else
    assign drive_en = |grant;
`endif

    // No data register: the owner's slice passes straight through, gated by the grant.
    assign bus_out = drive_en ? slices[owner] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// Scoreboard bench for bus_driver_arbiter: dut_a (TURN_CYCLES=1, MAX_HOLD=4) and
// dut_b (TURN_CYCLES=3, MAX_HOLD=0) share clock, reset and request/data stimulus.
module tb_bus_driver_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] g;
        logic [7:0] b;
        logic       busy;
    } step_t;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] b;
        logic       busy;
    } exp_t;

`ifdef BUS_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    localparam logic [31:0] DEF = 32'h13121110;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    wire  [7:0]  bus_a;
    wire  [7:0]  bus_b;
    logic [3:0]  grant_a;
    logic [3:0]  grant_b;
    logic [1:0]  owner_a;
    logic [1:0]  owner_b;
    logic        busy_a;
    logic        busy_b;

    int   checks;
    int   errors;
    exp_t sb[$];
    logic [7:0] dv [4];

    bus_driver_arbiter #(
        .WIDTH       (8),
        .SOURCES     (4),
        .TURN_CYCLES (1),
        .MAX_HOLD    (4)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .bus_out  (bus_a),
        .grant    (grant_a),
        .owner    (owner_a),
        .bus_busy (busy_a)
    );

    bus_driver_arbiter #(
        .WIDTH       (8),
        .SOURCES     (4),
        .TURN_CYCLES (3),
        .MAX_HOLD    (0)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .bus_out  (bus_b),
        .grant    (grant_b),
        .owner    (owner_b),
        .bus_busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] idle_bus(input logic [7:0] d);
        return PARK ? d : 8'hzz;
    endfunction

    function automatic step_t mk(input logic [3:0] r, input logic [3:0] g,
                                 input logic [7:0] b, input logic busy);
        return {r, g, b, busy};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (grant_a !== 4'b0 || bus_a !== idle_bus(8'h13) || busy_a !== 1'b0 || owner_a !== 2'd3) begin
            errors++;
            $display("FAIL reset_a: grant=%b bus=%h busy=%b owner=%0d, expected 0000 %h 0 3",
                     grant_a, bus_a, busy_a, owner_a, idle_bus(8'h13));
        end
        checks++;
        if (grant_b !== 4'b0 || bus_b !== idle_bus(8'h13) || busy_b !== 1'b0 || owner_b !== 2'd3) begin
            errors++;
            $display("FAIL reset_b: grant=%b bus=%h busy=%b owner=%0d, expected 0000 %h 0 3",
                     grant_b, bus_b, busy_b, owner_b, idle_bus(8'h13));
        end
        reset   = 1'b0;
        data_in = 32'h13A51110;
        req     = 4'b0100;
        cyc();
        checks++;
        if (grant_a !== 4'b0100 || bus_a !== 8'hA5 || owner_a !== 2'd2) begin
            errors++;
            $display("FAIL reset_pre_drive: grant=%b bus=%h owner=%0d, expected 0100 a5 2",
                     grant_a, bus_a, owner_a);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (grant_a !== 4'b0 || bus_a !== idle_bus(8'h13) || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drive: grant=%b bus=%h busy=%b, expected 0000 %h 0",
                     grant_a, bus_a, busy_a, idle_bus(8'h13));
        end
        checks++;
        if (owner_a !== 2'd3 || owner_b !== 2'd3) begin
            errors++;
            $display("FAIL reset_owner: owner_a=%0d owner_b=%0d, expected 3 3", owner_a, owner_b);
        end
        #1;
        reset   = 1'b0;
        req     = 4'b0;
        data_in = DEF;
        cyc();
    endtask

    task automatic test_single();
        step_t st[$];
        exp_t  e;
        req = 4'b0; reset = 1'b1; #2; reset = 1'b0;
        data_in = {DEF[31:8], 8'h3C};
        // Sole requester keeps the bus past MAX_HOLD.
        for (int i = 0; i < 6; i++) st.push_back(mk(4'b0001, 4'b0001, 8'h3C, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, idle_bus(8'h3C), 1'b0));
        st.push_back(mk(4'b0000, 4'b0000, idle_bus(8'h3C), 1'b0));
        foreach (st[k]) begin
            req = st[k].req;
            sb.push_back({st[k].g, st[k].b, st[k].busy});
            cyc();
            e = sb.pop_front();
            checks++;
            if (grant_a !== e.g || bus_a !== e.b || busy_a !== e.busy) begin
                errors++;
                $display("FAIL single[%0d]: grant=%b bus=%h busy=%b, expected %b %h %b",
                         k, grant_a, bus_a, busy_a, e.g, e.b, e.busy);
            end
        end
        checks++;
        if (owner_a !== 2'd0) begin
            errors++;
            $display("FAIL single_owner: owner=%0d, expected 0", owner_a);
        end
        data_in = DEF;
    endtask

    task automatic test_round_robin();
        step_t      st[$];
        exp_t       e;
        logic [3:0] oh;
        req = 4'b0; reset = 1'b1; #2; reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            st.push_back(mk(4'hF, oh, dv[i % 4], 1'b1));
            st.push_back(mk(4'hF, oh, dv[i % 4], 1'b1));
            st.push_back(mk(4'hF & ~oh, 4'h0, 8'hzz, 1'b1));
        end
        st.push_back(mk(4'h0, 4'h0, idle_bus(dv[0]), 1'b0));
        foreach (st[k]) begin
            req = st[k].req;
            sb.push_back({st[k].g, st[k].b, st[k].busy});
            cyc();
            e = sb.pop_front();
            checks++;
            if (grant_a !== e.g || bus_a !== e.b || busy_a !== e.busy) begin
                errors++;
                $display("FAIL round_robin[%0d]: grant=%b bus=%h busy=%b, expected %b %h %b",
                         k, grant_a, bus_a, busy_a, e.g, e.b, e.busy);
            end
        end
    endtask

    task automatic test_forced_release();
        step_t st[$];
        exp_t  e;
        req = 4'b0; reset = 1'b1; #2; reset = 1'b0;
        data_in = 32'h53125110;
        st.push_back(mk(4'b0010, 4'b0010, 8'h51, 1'b1));
        for (int i = 0; i < 3; i++) st.push_back(mk(4'b1010, 4'b0010, 8'h51, 1'b1));
        st.push_back(mk(4'b1010, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b1010, 4'b1000, 8'h53, 1'b1));
        st.push_back(mk(4'b0010, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0010, 4'b0010, 8'h51, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, idle_bus(8'h51), 1'b0));
        foreach (st[k]) begin
            req = st[k].req;
            sb.push_back({st[k].g, st[k].b, st[k].busy});
            cyc();
            e = sb.pop_front();
            checks++;
            if (grant_a !== e.g || bus_a !== e.b || busy_a !== e.busy) begin
                errors++;
                $display("FAIL forced_release[%0d]: grant=%b bus=%h busy=%b, expected %b %h %b",
                         k, grant_a, bus_a, busy_a, e.g, e.b, e.busy);
            end
        end
        checks++;
        if (owner_a !== 2'd1) begin
            errors++;
            $display("FAIL forced_owner: owner=%0d, expected 1", owner_a);
        end
        data_in = DEF;
    endtask

    task automatic test_turn3();
        step_t st[$];
        exp_t  e;
        req = 4'b0; reset = 1'b1; #2; reset = 1'b0;
        st.push_back(mk(4'b0001, 4'b0001, 8'h10, 1'b1));
        st.push_back(mk(4'b0100, 4'b0000, 8'hzz, 1'b1));
        // Requests seen only on the last turnaround cycle.
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0100, 4'b0100, 8'h12, 1'b1));
        for (int i = 0; i < 3; i++) st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, idle_bus(8'h12), 1'b0));
        foreach (st[k]) begin
            req = st[k].req;
            sb.push_back({st[k].g, st[k].b, st[k].busy});
            cyc();
            e = sb.pop_front();
            checks++;
            if (grant_b !== e.g || bus_b !== e.b || busy_b !== e.busy) begin
                errors++;
                $display("FAIL turn3[%0d]: grant=%b bus=%h busy=%b, expected %b %h %b",
                         k, grant_b, bus_b, busy_b, e.g, e.b, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        exp_t  e;
        req = 4'b0; reset = 1'b1; #2; reset = 1'b0;
        st.push_back(mk(4'b0100, 4'b0100, 8'h12, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0101, 4'b0001, 8'h10, 1'b1));
        st.push_back(mk(4'b0100, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0100, 4'b0100, 8'h12, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0100, 4'b0100, 8'h12, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 8'hzz, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, idle_bus(8'h12), 1'b0));
        foreach (st[k]) begin
            req = st[k].req;
            sb.push_back({st[k].g, st[k].b, st[k].busy});
            cyc();
            e = sb.pop_front();
            checks++;
            if (grant_a !== e.g || bus_a !== e.b || busy_a !== e.busy) begin
                errors++;
                $display("FAIL back_to_back[%0d]: grant=%b bus=%h busy=%b, expected %b %h %b",
                         k, grant_a, bus_a, busy_a, e.g, e.b, e.busy);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        dv[0]   = 8'h10;
        dv[1]   = 8'h11;
        dv[2]   = 8'h12;
        dv[3]   = 8'h13;
        reset   = 1'b1;
        req     = 4'b0;
        data_in = DEF;
        test_reset();
        test_single();
        test_round_robin();
        test_forced_release();
        test_turn3();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
